uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a byte FIFO and runtime frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. It sits between the host write port and the serial line, next to the baud-rate tick generator that supplies `s_tick`. Frames are sent back-to-back from the FIFO without host intervention. Every bit period is `OVS` ticks of `s_tick`.

---
 rtl/uart_tx_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO; frame format (5-8 data bits, parity, 1/2 stop)
// is latched per byte when it is popped, so host config changes never corrupt a frame.
module uart_tx_fifo #(
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_tick,
    input  logic                          wr_en,
    input  logic [7:0]                    din,
    input  logic [1:0]                    cfg_dbits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop,
    output logic                          tx,
    output logic                          tx_done,
    output logic                          tx_idle,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (OVS > 1) ? $clog2(OVS) : 1;

    localparam logic [CW-1:0] CountFull = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TickMax   = TW'(OVS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    // FIFO storage and pointers
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [7:0]    head;

    // Transmit datapath
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [1:0]    dbits_q, dbits_d;
    logic          par_en_q, par_en_d;
    logic          par_bit_q, par_bit_d;
    logic          stop2_q, stop2_d;
    logic          tx_q, tx_d;

    logic          tick_last;
    logic [7:0]    data_mask;
    logic          cfg_par_en;
    logic          cfg_par_bit;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push = wr_en && (count_q != CountFull);
    assign pop  = (state_q == StIdle) && (count_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Parity is precomputed from the masked head byte at pop time.
    assign data_mask   = 8'hFF >> (2'd3 - cfg_dbits);
    assign cfg_par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    assign cfg_par_bit = (^(head & data_mask)) ^ (cfg_parity == 2'b10);

    assign tick_last = s_tick && (tick_q == TickMax);

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        dbits_d   = dbits_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;

        if ((state_q != StIdle) && (state_q != StDone) && s_tick) begin
            tick_d = tick_last ? '0 : tick_q + TW'(1);
        end

        case (state_q)
            StIdle: begin
                if (pop) begin
                    shreg_d   = head;
                    dbits_d   = cfg_dbits;
                    par_en_d  = cfg_par_en;
                    par_bit_d = cfg_par_bit;
                    stop2_d   = cfg_stop;
                    tick_d    = '0;
                    bit_d     = '0;
                    tx_d      = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (tick_last) begin
                    tx_d    = shreg_q[0];
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (tick_last) begin
                    if (bit_q == ({1'b0, dbits_q} + 3'd4)) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            tx_d    = par_bit_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            StParity: begin
                if (tick_last) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick_last) begin
                    // bit_q counts completed stop bits: done after 1 or 2.
                    if (bit_q[0] == stop2_q) begin
                        state_d = StDone;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            dbits_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            dbits_q   <= dbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign tx_done    = (state_q == StDone);
    assign tx_idle    = (state_q == StIdle) && (count_q == '0);
    assign full       = (count_q == CountFull);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a serial-line
// monitor decodes tx tick by tick and checks each frame against the queue.
module tb_uart_tx_fifo;

    localparam int unsigned OVS        = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic       tick_raw;
    logic       tick_en;
    logic       wr_en;
    logic [7:0] din;
    logic [1:0] cfg_dbits;
    logic [1:0] cfg_parity;
    logic       cfg_stop;
    logic       tx;
    logic       tx_done;
    logic       tx_idle;
    logic       full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_tx_fifo #(
        .OVS        (OVS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tick     (s_tick),
        .wr_en      (wr_en),
        .din        (din),
        .cfg_dbits  (cfg_dbits),
        .cfg_parity (cfg_parity),
        .cfg_stop   (cfg_stop),
        .tx         (tx),
        .tx_done    (tx_done),
        .tx_idle    (tx_idle),
        .full       (full),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    assign s_tick = tick_raw && tick_en;

    initial begin
        tick_raw = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_raw = ~tick_raw;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         has_par;
        bit         par;
        int         nstop;
        bit         b2b;
    } frame_t;

    frame_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [7:0] data, input int nbits, input bit has_par,
                                input bit par, input int nstop, input bit b2b);
        frame_t f;
        f.data = data; f.nbits = nbits; f.has_par = has_par;
        f.par = par; f.nstop = nstop; f.b2b = b2b;
        exp_q.push_back(f);
    endtask

    // Monitor state
    bit         mon_active = 0;
    int         mon_bit    = 0;
    int         mon_ticks  = 0;
    bit         bit_start  = 0;
    bit         hold_bad   = 0;
    bit         done_pend  = 0;
    logic       cur_val;
    logic [11:0] bits;
    int         gap        = 0;
    int         total      = 0;
    int         aborted    = 0;
    frame_t     cur_exp;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mon_active) aborted++;
                mon_active = 0;
                done_pend  = 0;
                gap        = 0;
                continue;
            end
            if (done_pend) begin
                check("tx_done_pulse", tx_done, 1);
                done_pend = 0;
            end else if (tx_done) begin
                check("tx_done_spurious", tx_done, 0);
            end
            if (!mon_active) begin
                if (tx == 1'b0) begin
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur_exp = exp_q.pop_front();
                    end else begin
                        cur_exp.data = 8'h00; cur_exp.nbits = 8; cur_exp.has_par = 0;
                        cur_exp.par = 0; cur_exp.nstop = 1; cur_exp.b2b = 0;
                    end
                    if (cur_exp.b2b) check("interframe_gap", gap, 2);
                    mon_active = 1;
                    mon_bit    = 0;
                    mon_ticks  = 0;
                    bit_start  = 1;
                    hold_bad   = 0;
                    total      = 1 + cur_exp.nbits + int'(cur_exp.has_par) + cur_exp.nstop;
                end else begin
                    gap++;
                end
            end
            if (mon_active) begin
                if (bit_start) begin
                    cur_val       = tx;
                    bits[mon_bit] = tx;
                    bit_start     = 0;
                end else if (tx !== cur_val) begin
                    hold_bad = 1;
                end
                if (s_tick) begin
                    mon_ticks++;
                    if (mon_ticks == OVS) begin
                        mon_ticks = 0;
                        mon_bit++;
                        bit_start = 1;
                        if (mon_bit == total) begin
                            logic [7:0] d;
                            bit stop_ok;
                            d = 8'h00;
                            for (int i = 0; i < cur_exp.nbits; i++) d[i] = bits[i+1];
                            check("frame_data", d, cur_exp.data);
                            if (cur_exp.has_par)
                                check("frame_parity", bits[cur_exp.nbits+1], cur_exp.par);
                            stop_ok = 1;
                            for (int i = 0; i < cur_exp.nstop; i++)
                                if (bits[1+cur_exp.nbits+int'(cur_exp.has_par)+i] !== 1'b1)
                                    stop_ok = 0;
                            check("frame_stop", stop_ok, 1);
                            check("bit_hold", hold_bad, 0);
                            mon_active = 0;
                            done_pend  = 1;
                            gap        = 0;
                        end
                    end
                end
            end
        end
    end

    logic [7:0] wbuf [6];

    task automatic write_burst(input int n);
        @(posedge clk);
        #1;
        wr_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            din = wbuf[i];
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int max_clk, input string name);
        int i;
        for (i = 0; i < max_clk; i++) begin
            @(posedge clk);
            #1;
            if (tx_idle && !mon_active && !done_pend) break;
        end
        check(name, i < max_clk, 1);
    endtask

    task automatic wait_bit(input int tbit, input int tticks, input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (mon_active && mon_bit == tbit && mon_ticks == tticks) break;
        end
        check(name, i < 2000, 1);
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic [1:0] par, input logic st);
        cfg_dbits = db; cfg_parity = par; cfg_stop = st;
    endtask

    initial begin
        logic held;
        rst = 1'b1; wr_en = 1'b0; din = 8'h00; tick_en = 1'b1;
        set_cfg(2'd3, 2'b00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_idle", tx_idle, 1);
        check("rst_full", full, 0);
        check("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;

        // 8N1 0x55 with start-latency checks
        expect_frame(8'h55, 8, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        din = 8'h55; wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("lat_count_after_write", fifo_count, 1);
        check("lat_tx_high_after_write", tx, 1);
        @(posedge clk);
        #1;
        check("lat_tx_start", tx, 0);
        check("lat_count_after_pop", fifo_count, 0);
        wait_idle(2000, "idle_8n1");
        check("tx_idle_8n1", tx_idle, 1);

        // 7E2 and 7O2 of 0x41
        set_cfg(2'd2, 2'b01, 1'b1);
        expect_frame(8'h41, 7, 1, 0, 2, 0);
        wbuf[0] = 8'h41; write_burst(1);
        wait_idle(2000, "idle_7e2");
        set_cfg(2'd2, 2'b10, 1'b1);
        expect_frame(8'h41, 7, 1, 1, 2, 0);
        wbuf[0] = 8'h41; write_burst(1);
        wait_idle(2000, "idle_7o2");

        // 5O1 of 0xFF: upper bits never sent
        set_cfg(2'd0, 2'b10, 1'b0);
        expect_frame(8'h1F, 5, 1, 0, 1, 0);
        wbuf[0] = 8'hFF; write_burst(1);
        wait_idle(2000, "idle_5o1");

        // Burst A0..A5 in 8N1, A5 dropped
        set_cfg(2'd3, 2'b00, 1'b0);
        expect_frame(8'hA0, 8, 0, 0, 1, 0);
        for (int i = 1; i < 5; i++) expect_frame(8'hA0 + 8'(i), 8, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) wbuf[i] = 8'hA0 + 8'(i);
        write_burst(6);
        check("burst_full", full, 1);
        check("burst_count", fifo_count, 4);
        wait_idle(6000, "idle_burst");

        // Reset during data bit 3 with two bytes queued
        expect_frame(8'h11, 8, 0, 0, 1, 0);
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        write_burst(3);
        wait_bit(4, OVS / 2, "reach_data_bit3");
        check("pre_reset_count", fifo_count, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx", tx, 1);
        check("abort_fifo_count", fifo_count, 0);
        check("abort_tx_done", tx_done, 0);
        check("abort_full", full, 0);
        rst = 1'b0;
        repeat (800) @(posedge clk);
        #1;
        check("post_reset_idle", tx_idle, 1);
        check("aborted_frames", aborted, 1);

        // Stall during parity, then parity mode switch for the queued byte
        set_cfg(2'd3, 2'b01, 1'b0);
        expect_frame(8'hA7, 8, 1, 1, 1, 0);
        expect_frame(8'h3D, 8, 1, 0, 1, 1);
        wbuf[0] = 8'hA7; wbuf[1] = 8'h3D;
        write_burst(2);
        wait_bit(9, 5, "reach_parity");
        cfg_parity = 2'b10;
        tick_en    = 1'b0;
        held       = tx;
        repeat (100) @(posedge clk);
        #1;
        check("stall_tx_hold", tx, held);
        check("stall_parity_value", held, 1);
        check("stall_tick_count", mon_ticks, 5);
        tick_en = 1'b1;
        wait_idle(3000, "idle_stall");

        check("exp_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
